// File: rtl/cnt_seq_checker.sv
// Receive-side monitor for a free-running up-counter stream: locks once the stream increments cleanly,
// then flags, counts and reports breaks and wraps. Optional macro CNT_CHK_HOLD_ALLOW_EN makes a held value neutral.
module cnt_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_LEN   = 3,
  parameter int UNLOCK_LEN = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W = 4;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [RUN_W-1:0] match_run_q, match_run_d;
  logic [RUN_W-1:0] miss_run_q, miss_run_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic [WIDTH-1:0] succ;
  logic             is_cmp, is_hold, is_match, is_miss;
  logic             lock_hit, unlock_hit, at_top;

  assign succ     = prev_q + WIDTH'(1);
  assign is_cmp   = cnt_vld && have_prev_q;
`ifdef CNT_CHK_HOLD_ALLOW_EN
  assign is_hold  = is_cmp && (cnt_in == prev_q);
`else
  assign is_hold  = 1'b0;
`endif
  assign is_match   = is_cmp && (cnt_in == succ);
  assign is_miss    = is_cmp && !is_match && !is_hold;
  assign lock_hit   = (match_run_q + RUN_W'(1)) == RUN_W'(LOCK_LEN);
  assign unlock_hit = (miss_run_q + RUN_W'(1)) == RUN_W'(UNLOCK_LEN);
  assign at_top     = (prev_q == {WIDTH{1'b1}});

  // State register and all datapath flops; reset wins over any pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      match_run_q  <= '0;
      miss_run_q   <= '0;
      err_cnt_q    <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      match_run_q  <= match_run_d;
      miss_run_q   <= miss_run_d;
      err_cnt_q    <= err_cnt_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: if (is_match && lock_hit)   state_d = ST_LOCKED;
      ST_LOCKED: if (is_miss  && unlock_hit) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    match_run_d  = match_run_q;
    miss_run_d   = miss_run_q;
    err_cnt_d    = err_cnt_q;
    expected_d   = expected_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    locked_d     = (state_d == ST_LOCKED);

    // Always follow the real stream so a single glitch costs one error, not two.
    if (cnt_vld && !is_hold) begin
      prev_d      = cnt_in;
      have_prev_d = 1'b1;
      expected_d  = cnt_in + WIDTH'(1);
    end

    if (state_q == ST_SEARCH) begin
      if (is_match) begin
        match_run_d = match_run_q + RUN_W'(1);
        if (lock_hit) miss_run_d = '0;
      end else if (is_miss) begin
        match_run_d = '0;
      end
    end else begin
      if (is_match) begin
        miss_run_d   = '0;
        wrap_pulse_d = at_top;
      end else if (is_miss) begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
        if (unlock_hit) begin
          match_run_d = '0;
          miss_run_d  = '0;
        end else begin
          miss_run_d = miss_run_q + RUN_W'(1);
        end
      end
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Bench for cnt_seq_checker: directed scenarios plus a random stream, compared every cycle
// against a behavioural model of the checker's rules.
module tb_cnt_seq_checker;

  localparam int W      = 4;
  localparam int MOD    = 16;
  localparam int LOCK   = 3;
  localparam int UNLOCK = 2;
  localparam int EW     = 8;
  localparam int EMAX   = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  cnt_in = '0;
  logic          cnt_vld = 1'b0;
  logic          locked, err_pulse, wrap_pulse;
  logic [EW-1:0] err_cnt;
  logic [W-1:0]  expected;

  int checks = 0;
  int errors = 0;

  cnt_seq_checker #(.WIDTH(W), .LOCK_LEN(LOCK), .UNLOCK_LEN(UNLOCK), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_cnt(err_cnt), .expected(expected)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_prev, m_have, m_locked, m_run, m_miss, m_err, m_exp, m_errp, m_wrap;
  int wrap_seen;

  function automatic void model_reset();
    m_prev = 0; m_have = 0; m_locked = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_exp = 0; m_errp = 0; m_wrap = 0;
  endfunction

  function automatic void model(input bit rst, input bit vld, input int v);
    bit hold, good;
    m_errp = 0; m_wrap = 0;
    if (!rst) begin model_reset(); return; end
    if (!vld) return;
    if (m_have == 0) begin
      m_have = 1; m_prev = v; m_exp = (v + 1) % MOD;
      return;
    end
`ifdef CNT_CHK_HOLD_ALLOW_EN
    hold = (v == m_prev);
`else
    hold = 1'b0;
`endif
    if (hold) return;
    good = (v == (m_prev + 1) % MOD);
    if (m_locked != 0) begin
      if (good) begin
        m_miss = 0;
        if (v == 0) m_wrap = 1;
      end else begin
        m_errp = 1;
        if (m_err < EMAX) m_err++;
        m_miss++;
        if (m_miss == UNLOCK) begin m_locked = 0; m_run = 0; m_miss = 0; end
      end
    end else begin
      if (good) begin
        m_run++;
        if (m_run == LOCK) begin m_locked = 1; m_miss = 0; end
      end else begin
        m_run = 0;
      end
    end
    m_prev = v;
    m_exp  = (v + 1) % MOD;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("locked",     {31'd0, locked},     m_locked);
    check("err_pulse",  {31'd0, err_pulse},  m_errp);
    check("wrap_pulse", {31'd0, wrap_pulse}, m_wrap);
    check("err_cnt",    {24'd0, err_cnt},    m_err);
    check("expected",   {28'd0, expected},   m_exp);
  endtask

  task automatic step(input bit rst, input bit vld, input int v);
    rst_n   = rst;
    cnt_vld = vld;
    cnt_in  = W'(v);
    @(posedge clk);
    #1;
    model(rst, vld, v);
    if (wrap_pulse === 1'b1) wrap_seen++;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int e0, last, r;
    model_reset();
    wrap_seen = 0;

    // Reset state
    do_reset();
    do_reset();

    // Lock and wrap: 0..15,0,1
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1, i % MOD);
      if (i == 2) check("not_locked_at_2", {31'd0, locked}, 32'd0);
      if (i == 3) check("locked_at_3", {31'd0, locked}, 32'd1);
    end
    check("wrap_once", wrap_seen, 32'd1);
    check("lw_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("lw_expected", {28'd0, expected}, 32'd2);

    // Single glitch ...4,7,8,9
    e0 = m_err;
    step(1'b1, 1'b1, 2); step(1'b1, 1'b1, 3); step(1'b1, 1'b1, 4);
    step(1'b1, 1'b1, 7);
    check("glitch_pulse", {31'd0, err_pulse}, 32'd1);
    step(1'b1, 1'b1, 8); step(1'b1, 1'b1, 9);
    check("glitch_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("glitch_locked", {31'd0, locked}, 32'd1);

    // Unlock and relock ...5,9,2,3,4,5
    for (int v = 10; v < 22; v++) step(1'b1, 1'b1, v % MOD);
    e0 = int'(err_cnt);
    step(1'b1, 1'b1, 9);
    step(1'b1, 1'b1, 2);
    check("unlocked_after_2", {31'd0, locked}, 32'd0);
    check("unlock_err_delta", {24'd0, err_cnt}, e0 + 2);
    step(1'b1, 1'b1, 3);
    check("search_no_pulse", {31'd0, err_pulse}, 32'd0);
    step(1'b1, 1'b1, 4);
    check("still_search_at_4", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b1, 5);
    check("relocked_at_5", {31'd0, locked}, 32'd1);

    // Valid gaps with junk on cnt_in
    do_reset();
    for (int v = 0; v < 4; v++) step(1'b1, 1'b1, v);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, $urandom_range(0, MOD - 1));
    for (int v = 4; v < 7; v++) step(1'b1, 1'b1, v);
    check("gap_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("gap_locked", {31'd0, locked}, 32'd1);

    // Saturation: bad jump then good increment, 300 times
    last = 6;
    for (int k = 0; k < 300; k++) begin
      last = (last + 3) % MOD; step(1'b1, 1'b1, last);
      last = (last + 1) % MOD; step(1'b1, 1'b1, last);
    end
    check("sat_err_cnt", {24'd0, err_cnt}, EMAX);
    check("sat_locked", {31'd0, locked}, 32'd1);

    // Reset while locked with err_cnt=3
    do_reset();
    for (int v = 0; v < 5; v++) step(1'b1, 1'b1, v);
    step(1'b1, 1'b1, 8);  step(1'b1, 1'b1, 9);
    step(1'b1, 1'b1, 13); step(1'b1, 1'b1, 14);
    step(1'b1, 1'b1, 2);  step(1'b1, 1'b1, 3);
    check("pre_reset_err", {24'd0, err_cnt}, 32'd3);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 0);
    check("glitch_rst_locked", {31'd0, locked}, 32'd1);
    check("glitch_rst_err", {24'd0, err_cnt}, 32'd3);
    step(1'b0, 1'b1, 4);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // Held value: 4,4,5 while locked
    for (int v = 0; v < 5; v++) step(1'b1, 1'b1, v);
    e0 = int'(err_cnt);
    step(1'b1, 1'b1, 4);
`ifdef CNT_CHK_HOLD_ALLOW_EN
    check("hold_no_pulse", {31'd0, err_pulse}, 32'd0);
`else
    check("hold_pulse", {31'd0, err_pulse}, 32'd1);
`endif
    step(1'b1, 1'b1, 5);
`ifdef CNT_CHK_HOLD_ALLOW_EN
    check("hold_err_delta", {24'd0, err_cnt}, e0);
`else
    check("hold_err_delta", {24'd0, err_cnt}, e0 + 1);
`endif
    check("hold_locked", {31'd0, locked}, 32'd1);

    // Random stream: mostly increments, occasional jumps/holds, gaps and resets
    last = 0;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        step(1'b0, $urandom_range(0, 1), $urandom_range(0, MOD - 1));
      end else if (r < 20) begin
        step(1'b1, 1'b0, $urandom_range(0, MOD - 1));
      end else begin
        if (r < 28)      last = $urandom_range(0, MOD - 1);
        else if (r < 32) last = last;
        else             last = (last + 1) % MOD;
        step(1'b1, 1'b1, last);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
